// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad reader with frame-level debounce.
// Rotates active-low columns, samples rows, reports one accepted key.
module keypad_scanner #(
   parameter int SCAN_DIV = 50000,
   parameter int DEBOUNCE = 4
) (
   input  logic       clock_in,
   input  logic       CLR,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key,
   output logic       key_valid,
   output logic       key_held
);

   typedef enum logic [1:0] {
      RES_NONE  = 2'd0,
      RES_ONE   = 2'd1,
      RES_MULTI = 2'd2
   } res_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_HELD = 1'b1
   } state_t;

   localparam logic [27:0] TICK_LAST = 28'(SCAN_DIV - 1);
   localparam logic [3:0]  DB_MAX    = 4'(DEBOUNCE);

   logic [3:0]  row_meta;
   logic [3:0]  row_sync;
   logic [27:0] tick;
   logic [1:0]  col_idx;
   logic [1:0]  acc_cnt;
   logic [3:0]  acc_code;
   res_t        cand_type;
   logic [3:0]  cand_code;
   logic [3:0]  stable_cnt;
   state_t      state;

   logic        sample;
   logic        frame_end;
   logic [2:0]  col_hits;
   logic [1:0]  first_row;
   logic [1:0]  sum_cnt;
   logic [3:0]  sum_code;
   res_t        frame_type;
   logic [3:0]  frame_code;
   logic        same;
   logic [3:0]  next_cnt;

   assign sample    = (tick == TICK_LAST);
   assign frame_end = sample && (col_idx == 2'd3);

   // Two-flop synchronizer; rows idle high so reset to all ones
   always_ff @(posedge clock_in) begin
      if (CLR) begin
         row_meta <= 4'hF;
         row_sync <= 4'hF;
      end else begin
         row_meta <= row;
         row_sync <= row_meta;
      end
   end

   // Column period timer and column rotation
   always_ff @(posedge clock_in) begin
      if (CLR) begin
         tick    <= 28'd0;
         col_idx <= 2'd0;
      end else if (sample) begin
         tick    <= 28'd0;
         col_idx <= col_idx + 2'd1;
      end else begin
         tick    <= tick + 28'd1;
      end
   end

   // Active-low one-hot column drive
   always_comb begin
      col = 4'b1110;
      unique case (col_idx)
         2'd0: col = 4'b1110;
         2'd1: col = 4'b1101;
         2'd2: col = 4'b1011;
         2'd3: col = 4'b0111;
      endcase
   end

   // Pressed rows in the current column; lowest row index wins
   always_comb begin
      col_hits  = 3'd0;
      first_row = 2'd0;
      for (int r = 3; r >= 0; r--) begin
         if (!row_sync[r]) begin
            col_hits  = col_hits + 3'd1;
            first_row = 2'(r);
         end
      end
   end

   // Merge this column into the running frame tally
   always_comb begin
      sum_cnt  = acc_cnt;
      sum_code = acc_code;
      if (col_hits != 3'd0) begin
         if (acc_cnt == 2'd0) begin
            sum_code = {col_idx, first_row};
         end
         if ((acc_cnt == 2'd0) && (col_hits == 3'd1)) begin
            sum_cnt = 2'd1;
         end else begin
            sum_cnt = 2'd2;
         end
      end
   end

   // Classify the frame and step the stability counter
   always_comb begin
      frame_type = RES_NONE;
      frame_code = 4'h0;
      if (sum_cnt == 2'd1) begin
         frame_type = RES_ONE;
         frame_code = sum_code;
      end else if (sum_cnt != 2'd0) begin
         frame_type = RES_MULTI;
      end
      same = (frame_type == cand_type) &&
             (frame_code == cand_code);
      if (!same) begin
         next_cnt = 4'd1;
      end else if (stable_cnt == DB_MAX) begin
         next_cnt = stable_cnt;
      end else begin
         next_cnt = stable_cnt + 4'd1;
      end
   end

   // Frame accumulator: tally at each sample, clear at frame end
   always_ff @(posedge clock_in) begin
      if (CLR || frame_end) begin
         acc_cnt  <= 2'd0;
         acc_code <= 4'h0;
      end else if (sample) begin
         acc_cnt  <= sum_cnt;
         acc_code <= sum_code;
      end
   end

   // Debounce candidate and run length of identical frames
   always_ff @(posedge clock_in) begin
      if (CLR) begin
         cand_type  <= RES_NONE;
         cand_code  <= 4'h0;
         stable_cnt <= 4'd0;
      end else if (frame_end) begin
         cand_type  <= frame_type;
         cand_code  <= frame_code;
         stable_cnt <= next_cnt;
      end
   end

   // Press/release FSM with n-key lockout while held
   always_ff @(posedge clock_in) begin
      if (CLR) begin
         state     <= S_IDLE;
         key       <= 4'h0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         if (frame_end && (next_cnt == DB_MAX)) begin
            unique case (state)
               S_IDLE: begin
                  if (frame_type == RES_ONE) begin
                     key       <= frame_code;
                     key_valid <= 1'b1;
                     key_held  <= 1'b1;
                     state     <= S_HELD;
                  end
               end
               S_HELD: begin
                  if (frame_type == RES_NONE) begin
                     key_held <= 1'b0;
                     state    <= S_IDLE;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scan, debounce and lockout.
// Keypad model pulls a row low only while its column is driven.
module tb_keypad_scanner;

   logic       clk;
   logic       CLR;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key;
   logic       key_valid;
   logic       key_held;

   logic [15:0] keys;

   int n_cmp;
   int n_bad;
   int cyc;
   int pulses;
   int pulse_cyc;
   int pulse_key;
   int held_cycles;
   int p0;
   int h0;

   keypad_scanner #(
      .SCAN_DIV (4),
      .DEBOUNCE (2)
   ) dut (
      .clock_in  (clk),
      .CLR       (CLR),
      .row       (row),
      .col       (col),
      .key       (key),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad matrix: key code {col,row} is bit index in keys
   always_comb begin
      row = 4'hF;
      for (int c = 0; c < 4; c++) begin
         if (!col[c]) row = row & ~keys[c*4 +: 4];
      end
   end

   // Cycle index since reset release; equals tick + 4*col_idx
   always @(posedge clk) begin
      if (CLR) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   // Strobe and held monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (key_valid) begin
         pulses    = pulses + 1;
         pulse_cyc = cyc;
         pulse_key = int'(key);
      end
      if (key_held) held_cycles = held_cycles + 1;
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      #1 CLR = 1'b1;
      repeat (n) @(negedge clk);
      #1 CLR = 1'b0;
   endtask

   initial begin
      n_cmp       = 0;
      n_bad       = 0;
      pulses      = 0;
      pulse_cyc   = -1;
      pulse_key   = -1;
      held_cycles = 0;
      keys        = 16'h0000;
      CLR         = 1'b1;
      repeat (3) @(negedge clk);
      #1 CLR = 1'b0;
      step(6);

      // Reset mid-scan, then column rotation
      @(negedge clk);
      #1 CLR = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_col", 32'(col), 32'hE);
      chk("rst_key", 32'(key), 32'h0);
      chk("rst_kv", 32'(key_valid), 32'h0);
      chk("rst_held", 32'(key_held), 32'h0);
      CLR = 1'b0;
      chk("col0", 32'(col), 32'hE);
      step(4);
      chk("col1", 32'(col), 32'hD);
      step(4);
      chk("col2", 32'(col), 32'hB);
      step(4);
      chk("col3", 32'(col), 32'h7);
      step(4);
      chk("col_wrap", 32'(col), 32'hE);

      // Single press of key 6 from frame 0
      do_reset(2);
      keys = 16'h0040;
      p0 = pulses;
      step(31);
      chk("sp_kv_early", 32'(key_valid), 32'h0);
      chk("sp_held_early", 32'(key_held), 32'h0);
      step(1);
      chk("sp_kv", 32'(key_valid), 32'h1);
      chk("sp_key", 32'(key), 32'h6);
      chk("sp_held", 32'(key_held), 32'h1);
      step(1);
      chk("sp_kv_off", 32'(key_valid), 32'h0);
      step(31);
      chk("sp_pulses", 32'(pulses - p0), 32'd1);
      chk("sp_pcyc", 32'(pulse_cyc), 32'd32);

      // Bounce: press toggles every frame
      keys = 16'h0000;
      do_reset(2);
      p0 = pulses;
      h0 = held_cycles;
      for (int f = 0; f < 6; f++) begin
         keys = (f % 2 == 0) ? 16'h0040 : 16'h0000;
         step(16);
      end
      chk("bn_pulses", 32'(pulses - p0), 32'd0);
      chk("bn_heldcyc", 32'(held_cycles - h0), 32'd0);
      chk("bn_held", 32'(key_held), 32'h0);

      // Multi-key 6+9, then 9 released
      keys = 16'h0000;
      do_reset(2);
      keys = 16'h0240;
      p0 = pulses;
      step(48);
      chk("mk_pulses", 32'(pulses - p0), 32'd0);
      chk("mk_held", 32'(key_held), 32'h0);
      keys = 16'h0040;
      step(31);
      chk("mk_kv_early", 32'(key_valid), 32'h0);
      step(1);
      chk("mk_kv", 32'(key_valid), 32'h1);
      chk("mk_key", 32'(key), 32'h6);
      step(16);
      chk("mk_pulses2", 32'(pulses - p0), 32'd1);

      // Lockout: add 3, drop 6, then release all
      p0 = pulses;
      keys = 16'h0048;
      step(16);
      keys = 16'h0008;
      step(48);
      chk("lo_pulses", 32'(pulses - p0), 32'd0);
      chk("lo_held", 32'(key_held), 32'h1);
      chk("lo_key", 32'(key), 32'h6);
      keys = 16'h0000;
      step(31);
      chk("rl_held_early", 32'(key_held), 32'h1);
      step(1);
      chk("rl_held", 32'(key_held), 32'h0);
      chk("rl_key", 32'(key), 32'h6);
      chk("rl_pulses", 32'(pulses - p0), 32'd0);

      // Reset mid-debounce discards the partial run
      do_reset(2);
      chk("rd_key_clr", 32'(key), 32'h0);
      chk("rd_held_clr", 32'(key_held), 32'h0);
      keys = 16'h0040;
      p0 = pulses;
      step(20);
      do_reset(1);
      step(31);
      chk("rd_pulses_early", 32'(pulses - p0), 32'd0);
      chk("rd_kv_early", 32'(key_valid), 32'h0);
      step(1);
      chk("rd_kv", 32'(key_valid), 32'h1);
      chk("rd_key", 32'(key), 32'h6);
      chk("rd_pulses", 32'(pulses - p0), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
